// File: rtl/mtr_incr_sched_if.sv
// Bundle of meter-scheduler signals shared between the MTR counters, the PI
// board and the EBUS read mux. The slave modport is the scheduler's view and
// the master modport is the view of whatever drives it.
interface mtr_incr_sched_if #(
    parameter int NSRC = 4,
    parameter int SELW = 2
);
    logic [NSRC-1:0] OVF;
    logic            INTERVAL_DONE;
    logic [2:0]      MTR_PIA;
    logic            MTR_HONOR;
    logic            INCR_DONE;
    logic            CLR_LOST;
    logic            INTERRUPT_REQ;
    logic            VECTOR_REQ;
    logic [SELW-1:0] INCR_SEL;
    logic [NSRC-1:0] PENDING;
    logic [NSRC-1:0] LOST;

    modport slave (
        input  OVF, INTERVAL_DONE, MTR_PIA, MTR_HONOR, INCR_DONE, CLR_LOST,
        output INTERRUPT_REQ, VECTOR_REQ, INCR_SEL, PENDING, LOST
    );

    modport master (
        output OVF, INTERVAL_DONE, MTR_PIA, MTR_HONOR, INCR_DONE, CLR_LOST,
        input  INTERRUPT_REQ, VECTOR_REQ, INCR_SEL, PENDING, LOST
    );
endinterface

// File: rtl/mtr_incr_sched.sv
// Meter-counter overflow scheduler. Counter carries are latched as pending
// increments and served one at a time: request the PI, wait for the honor,
// then hold INCR_SEL/VECTOR_REQ frozen until microcode reports INCR_DONE.
// The interval-timer vector is the lowest-priority service.
// Optional feature: define MTR_SCHED_ROUND_ROBIN_EN to pick counters
// round-robin after the last-served index instead of fixed priority.
module mtr_incr_sched #(
    parameter int NSRC = 4,
    parameter int SELW = 2
) (
    input  logic                clk,
    input  logic                RESET,
    mtr_incr_sched_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERVE} state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic            vec_q, vec_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] lost_q, lost_d;
    logic [NSRC-1:0] clr_w;
    logic [NSRC-1:0] loss_w;
    logic            done_cnt_w;
    logic [SELW-1:0] pick_w;

    // Fixed priority: lowest set index wins.
    function automatic logic [SELW-1:0] pick_fixed(input logic [NSRC-1:0] p);
        logic [SELW-1:0] s;
        s = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (p[SELW'(i)]) s = SELW'(i);
        end
        return s;
    endfunction

`ifdef MTR_SCHED_ROUND_ROBIN_EN
    logic [SELW-1:0] last_q, last_d;

    // Round robin: first pending index strictly after 'last', wrapping.
    function automatic logic [SELW-1:0] pick_rr(input logic [NSRC-1:0] p,
                                                input logic [SELW-1:0] last);
        logic [SELW-1:0] s;
        int              idx;
        s = '0;
        for (int k = NSRC; k >= 1; k--) begin
            idx = (int'(last) + k) % NSRC;
            if (p[SELW'(idx)]) s = SELW'(idx);
        end
        return s;
    endfunction

    assign pick_w = pick_rr(pend_q, last_q);

    // Remember the counter just finished; the vector never moves the pointer.
    always_comb begin
        last_d = last_q;
        if (done_cnt_w) last_d = sel_q;
    end

    // Pointer starts at the top index so the first pick after reset is 0.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) last_q <= SELW'(NSRC - 1);
        else       last_q <= last_d;
    end
`else
    assign pick_w = pick_fixed(pend_q);
`endif

    // A counter (not vector) service completes this cycle.
    assign done_cnt_w = (state_q == SERVE) && bus.INCR_DONE && !vec_q;

    // Pending/lost bookkeeping: a same-cycle carry re-arms the bit being cleared
    // without counting as a loss; CLR_LOST never masks a loss arriving with it.
    always_comb begin
        clr_w = '0;
        for (int i = 0; i < NSRC; i++) begin
            clr_w[i] = done_cnt_w && (sel_q == SELW'(i));
        end
        loss_w = bus.OVF & pend_q & ~clr_w;
        pend_d = (pend_q & ~clr_w) | bus.OVF;
        lost_d = bus.CLR_LOST ? loss_w : (lost_q | loss_w);
    end

    // Next-state and select latching; the select is only ever changed on the
    // way out of IDLE or back into it, so it stays frozen through SERVE.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        vec_d   = vec_q;
        case (state_q)
            IDLE: begin
                sel_d = '0;
                vec_d = 1'b0;
                if (bus.MTR_PIA != 3'b000 && (|pend_q || bus.INTERVAL_DONE)) begin
                    state_d = REQ;
                    if (|pend_q) sel_d = pick_w;
                    else         vec_d = 1'b1;
                end
            end
            REQ: begin
                if (bus.MTR_HONOR) begin
                    state_d = SERVE;
                end else if (bus.MTR_PIA == 3'b000) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    vec_d   = 1'b0;
                end
            end
            SERVE: begin
                if (bus.INCR_DONE) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    vec_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                vec_d   = 1'b0;
            end
        endcase
    end

    // State, select and flag registers.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            sel_q   <= '0;
            vec_q   <= 1'b0;
            pend_q  <= '0;
            lost_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            vec_q   <= vec_d;
            pend_q  <= pend_d;
            lost_q  <= lost_d;
        end
    end

    assign bus.INTERRUPT_REQ = (state_q == REQ);
    assign bus.VECTOR_REQ    = vec_q;
    assign bus.INCR_SEL      = sel_q;
    assign bus.PENDING       = pend_q;
    assign bus.LOST          = lost_q;

endmodule

// File: tb/tb_mtr_incr_sched.sv
// Bench for mtr_incr_sched: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_mtr_incr_sched;
    localparam int NSRC = 4;
    localparam int SELW = 2;

    logic clk;
    logic RESET;
    int   checks;
    int   errors;

    mtr_incr_sched_if #(.NSRC(NSRC), .SELW(SELW)) bus ();

    mtr_incr_sched #(.NSRC(NSRC), .SELW(SELW)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the scheduler is doing, in words.
    bit       m_busy_req;    // interrupt request outstanding
    bit       m_busy_serve;  // microcode is working on a service
    bit       m_vec;
    int       m_sel;
    bit [3:0] m_pend;
    bit [3:0] m_lost;
    int       m_last;

    task automatic model_reset();
        m_busy_req   = 0;
        m_busy_serve = 0;
        m_vec        = 0;
        m_sel        = 0;
        m_pend       = '0;
        m_lost       = '0;
        m_last       = NSRC - 1;
    endtask

    function automatic int model_pick(bit [3:0] p);
        int order[$];
`ifdef MTR_SCHED_ROUND_ROBIN_EN
        for (int k = 1; k <= NSRC; k++) order.push_back((m_last + k) % NSRC);
`else
        for (int k = 0; k < NSRC; k++) order.push_back(k);
`endif
        foreach (order[j]) if (p[order[j]]) return order[j];
        return 0;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_clock();
        bit [3:0] served;
        bit [3:0] newloss;
        served = '0;
        if (m_busy_serve && bus.INCR_DONE && !m_vec) served[m_sel] = 1'b1;
        newloss = bus.OVF & m_pend & ~served;
        if (bus.CLR_LOST) m_lost = newloss;
        else              m_lost = m_lost | newloss;
        if (m_busy_serve) begin
            if (bus.INCR_DONE) begin
                if (!m_vec) m_last = m_sel;
                m_busy_serve = 0;
                m_sel = 0;
                m_vec = 0;
            end
        end else if (m_busy_req) begin
            if (bus.MTR_HONOR) begin
                m_busy_req = 0;
                m_busy_serve = 1;
            end else if (bus.MTR_PIA == 0) begin
                m_busy_req = 0;
                m_sel = 0;
                m_vec = 0;
            end
        end else begin
            m_sel = 0;
            m_vec = 0;
            if (bus.MTR_PIA != 0 && (m_pend != 0 || bus.INTERVAL_DONE)) begin
                m_busy_req = 1;
                if (m_pend != 0) m_sel = model_pick(m_pend);
                else             m_vec = 1;
            end
        end
        m_pend = (m_pend & ~served) | bus.OVF;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("irq",     int'(bus.INTERRUPT_REQ), int'(m_busy_req));
        chk("vec",     int'(bus.VECTOR_REQ),    int'(m_vec));
        chk("sel",     int'(bus.INCR_SEL),      m_sel);
        chk("pending", int'(bus.PENDING),       int'(m_pend));
        chk("lost",    int'(bus.LOST),          int'(m_lost));
    endtask

    // One clock: model follows the applied inputs, outputs checked 1ns after the edge.
    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
        chk_model();
    endtask

    task automatic idle_inputs();
        bus.OVF = '0;
        bus.INTERVAL_DONE = 0;
        bus.MTR_HONOR = 0;
        bus.INCR_DONE = 0;
        bus.CLR_LOST = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        bus.MTR_PIA = 3'd0;
        RESET = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_irq",  int'(bus.INTERRUPT_REQ), 0);
        chk("rst_vec",  int'(bus.VECTOR_REQ), 0);
        chk("rst_sel",  int'(bus.INCR_SEL), 0);
        chk("rst_pend", int'(bus.PENDING), 0);
        chk("rst_lost", int'(bus.LOST), 0);
        RESET = 1'b0;

        // Single overflow, full service.
        bus.MTR_PIA = 3'd3;
        bus.OVF = 4'b0001;
        tick();
        chk("t1_pend", int'(bus.PENDING), 1);
        chk("t1_noreq", int'(bus.INTERRUPT_REQ), 0);
        bus.OVF = '0;
        tick();
        chk("t1_req", int'(bus.INTERRUPT_REQ), 1);
        bus.MTR_HONOR = 1;
        tick();
        bus.MTR_HONOR = 0;
        chk("t1_serve_irq", int'(bus.INTERRUPT_REQ), 0);
        chk("t1_sel", int'(bus.INCR_SEL), 0);
        bus.INCR_DONE = 1;
        tick();
        bus.INCR_DONE = 0;
        chk("t1_done_pend", int'(bus.PENDING), 0);

        // Two simultaneous overflows served in order 1 then 3.
        bus.OVF = 4'b1010;
        tick();
        bus.OVF = '0;
        tick();
        chk("t2_first", int'(bus.INCR_SEL), 1);
        bus.MTR_HONOR = 1;
        tick();
        bus.MTR_HONOR = 0;
        bus.INCR_DONE = 1;
        tick();
        bus.INCR_DONE = 0;
        chk("t2_pend_mid", int'(bus.PENDING), 4'b1000);
        tick();
        chk("t2_second", int'(bus.INCR_SEL), 3);
        bus.MTR_HONOR = 1;
        tick();
        bus.MTR_HONOR = 0;
        bus.INCR_DONE = 1;
        tick();
        bus.INCR_DONE = 0;

        // Lost overflow and CLR_LOST.
        bus.MTR_PIA = 3'd0;
        bus.OVF = 4'b0100;
        tick();
        bus.OVF = '0;
        tick();
        bus.OVF = 4'b0100;
        tick();
        bus.OVF = '0;
        chk("t3_lost", int'(bus.LOST), 4'b0100);
        bus.CLR_LOST = 1;
        tick();
        bus.CLR_LOST = 0;
        chk("t3_lost_clr", int'(bus.LOST), 0);
        chk("t3_pend", int'(bus.PENDING), 4'b0100);
        bus.MTR_PIA = 3'd5;
        tick();
        bus.MTR_HONOR = 1;
        tick();
        bus.MTR_HONOR = 0;
        bus.INCR_DONE = 1;
        tick();
        bus.INCR_DONE = 0;

        // Carry arriving with the completion of the same counter.
        bus.OVF = 4'b0001;
        tick();
        bus.OVF = '0;
        tick();
        bus.MTR_HONOR = 1;
        tick();
        bus.MTR_HONOR = 0;
        bus.INCR_DONE = 1;
        bus.OVF = 4'b0001;
        tick();
        bus.INCR_DONE = 0;
        bus.OVF = '0;
        chk("t4_pend", int'(bus.PENDING), 1);
        chk("t4_lost", int'(bus.LOST), 0);
        chk("t4_gap", int'(bus.INTERRUPT_REQ), 0);
        tick();
        chk("t4_rereq", int'(bus.INTERRUPT_REQ), 1);
        bus.MTR_HONOR = 1;
        tick();
        bus.MTR_HONOR = 0;
        bus.INCR_DONE = 1;
        tick();
        bus.INCR_DONE = 0;

        // Interval vector, then request withdrawn by PIA=0.
        bus.INTERVAL_DONE = 1;
        tick();
        chk("t5_vec", int'(bus.VECTOR_REQ), 1);
        chk("t5_sel", int'(bus.INCR_SEL), 0);
        chk("t5_req", int'(bus.INTERRUPT_REQ), 1);
        bus.MTR_PIA = 3'd0;
        tick();
        chk("t5_drop", int'(bus.INTERRUPT_REQ), 0);
        bus.MTR_HONOR = 1;
        tick();
        bus.MTR_HONOR = 0;
        chk("t5_nohonor", int'(bus.INTERRUPT_REQ), 0);
        chk("t5_vec_clr", int'(bus.VECTOR_REQ), 0);
        bus.INTERVAL_DONE = 0;

        // Asynchronous reset in the middle of a service.
        bus.MTR_PIA = 3'd3;
        bus.OVF = 4'b0010;
        tick();
        bus.OVF = '0;
        tick();
        bus.MTR_HONOR = 1;
        tick();
        bus.MTR_HONOR = 0;
        chk("t6_sel_before", int'(bus.INCR_SEL), 1);
        #2;
        RESET = 1'b1;
        model_reset();
        #1;
        chk("t6_irq", int'(bus.INTERRUPT_REQ), 0);
        chk("t6_sel", int'(bus.INCR_SEL), 0);
        chk("t6_pend", int'(bus.PENDING), 0);
        chk("t6_lost", int'(bus.LOST), 0);
        bus.MTR_PIA = 3'd0;
        @(posedge clk);
        #1;
        RESET = 1'b0;
        bus.OVF = 4'b0010;
        tick();
        bus.OVF = '0;
        tick();
        tick();
        chk("t6_no_req", int'(bus.INTERRUPT_REQ), 0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            bus.OVF           = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            bus.INTERVAL_DONE = ($urandom_range(0, 7) == 0);
            bus.MTR_PIA       = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            bus.MTR_HONOR     = ($urandom_range(0, 2) == 0);
            bus.INCR_DONE     = ($urandom_range(0, 2) == 0);
            bus.CLR_LOST      = ($urandom_range(0, 15) == 0);
            tick();
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
